// File: rtl/responder_pkg.sv
// Shared constants and state encoding for the quiz responder arbiter.
package responder_pkg;

  // Width of the winning-contestant index.
  localparam int ID_W  = 3;
  // Width of the remaining-seconds counter.
  localparam int SEC_W = 5;

  // Round states, kept as plain constants so older tools can read them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ARMED     = 3'd1;
  localparam state_t ST_ANSWERING = 3'd2;
  localparam state_t ST_TIMEOUT   = 3'd3;
  localparam state_t ST_JUDGED    = 3'd4;

endpackage

// File: rtl/responder_arbiter_sec_tick_gen.sv
// One-second tick generator: counts 0..TICK_DIV-1 while enabled and
// raises tick for the single cycle in which the count wraps.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider count; clr forces a fresh second to start on the next enable.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is always written with <= so every flop
    // samples the pre-edge values of its neighbours.
    if (RST || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (r_cnt == LAST);

endmodule

// File: rtl/responder_arbiter.sv
// Quiz responder control stage: first-press arbitration, foul lockout,
// per-answer countdown and beep/level requests for the tone generator.
module responder_arbiter
  import responder_pkg::*;
#(
  parameter int N_PLAYERS   = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int ANSWER_SECS = 30,
  parameter int BEEP_CYCLES = 10_000_000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_PLAYERS-1:0] Key_In,
  input  logic                 Host_Start,
  input  logic                 Host_Judge_True,
  input  logic                 Host_Clear,
  output logic [ID_W-1:0]      Winner_Id,
  output logic                 Winner_Valid,
  output logic [N_PLAYERS-1:0] Foul_Mask,
  output logic [SEC_W-1:0]     Count_Sec,
  output logic                 Buzzer_Answer,
  output logic                 Buzzer_TimeOver,
  output logic                 Answer_true,
  output logic                 TimeOver_Stop
);

  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [BW-1:0]    BEEP_LOAD = BW'(BEEP_CYCLES);
  localparam logic [SEC_W-1:0] SEC_LOAD  = SEC_W'(ANSWER_SECS);

  logic [N_PLAYERS-1:0] r_sync1, r_sync2, r_prev;
  logic [N_PLAYERS-1:0] w_press, w_eligible;
  logic                 w_win_found;
  logic [ID_W-1:0]      w_win_idx;
  logic                 w_tick;

  state_t               r_state;
  logic [ID_W-1:0]      r_winner_id;
  logic                 r_winner_valid;
  logic [N_PLAYERS-1:0] r_foul;
  logic [SEC_W-1:0]     r_count_sec;
  logic [BW-1:0]        r_ans_cnt, r_tov_cnt;
  logic                 r_answer_true, r_timeover;

  // Two-flop synchroniser plus one history flop for rising-edge detect.
  // Host_Clear leaves these alone so a key held across a clear never
  // produces a fresh press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= Key_In;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_press    = r_sync2 & ~r_prev;
  assign w_eligible = w_press & ~r_foul;

  // Lowest-index eligible press wins a simultaneous tie.
  always_comb begin
    // NOTE: defaults first so no path leaves these unassigned (no latch).
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win_found = 1'b1;
        w_win_idx   = ID_W'(i);
      end
    end
  end

  // The divider only runs while an answer is being timed.
  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (r_state != ST_ANSWERING),
    .en   (r_state == ST_ANSWERING),
    .tick (w_tick)
  );

  // Round FSM, flags, countdown and beep counters; Host_Clear outranks all.
  always_ff @(posedge CLK) begin
    if (RST || Host_Clear) begin
      r_state        <= ST_IDLE;
      r_winner_id    <= '0;
      r_winner_valid <= 1'b0;
      r_foul         <= '0;
      r_count_sec    <= '0;
      r_ans_cnt      <= '0;
      r_tov_cnt      <= '0;
      r_answer_true  <= 1'b0;
      r_timeover     <= 1'b0;
    end else begin
      if (r_ans_cnt != '0) r_ans_cnt <= r_ans_cnt - 1'b1;
      if (r_tov_cnt != '0) r_tov_cnt <= r_tov_cnt - 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_foul <= r_foul | w_press;
          if (Host_Start) begin
            r_state     <= ST_ARMED;
            r_count_sec <= SEC_LOAD;
          end
        end
        ST_ARMED: begin
          if (w_win_found) begin
            r_state        <= ST_ANSWERING;
            r_winner_id    <= w_win_idx;
            r_winner_valid <= 1'b1;
            r_ans_cnt      <= BEEP_LOAD;
          end
        end
        ST_ANSWERING: begin
          if (w_tick && r_count_sec <= 1) begin
            // Final tick beats a same-cycle judge.
            r_state     <= ST_TIMEOUT;
            r_count_sec <= '0;
            r_timeover  <= 1'b1;
            r_tov_cnt   <= BEEP_LOAD;
          end else begin
            if (w_tick) r_count_sec <= r_count_sec - 1'b1;
            if (Host_Judge_True) begin
              r_state       <= ST_JUDGED;
              r_answer_true <= 1'b1;
            end
          end
        end
        default: begin
          // TIMEOUT and JUDGED hold until Host_Clear.
        end
      endcase
    end
  end

  assign Winner_Id       = r_winner_id;
  assign Winner_Valid    = r_winner_valid;
  assign Foul_Mask       = r_foul;
  assign Count_Sec       = r_count_sec;
  assign Buzzer_Answer   = (r_ans_cnt != '0);
  assign Buzzer_TimeOver = (r_tov_cnt != '0);
  assign Answer_true     = r_answer_true;
  assign TimeOver_Stop   = r_timeover;

endmodule

// File: tb/tb_responder_arbiter.sv
// Directed bench for responder_arbiter with a small timing configuration.
module tb_responder_arbiter;

  localparam int NP = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NP-1:0] Key_In;
  logic          Host_Start, Host_Judge_True, Host_Clear;
  logic [2:0]    Winner_Id;
  logic          Winner_Valid;
  logic [NP-1:0] Foul_Mask;
  logic [4:0]    Count_Sec;
  logic          Buzzer_Answer, Buzzer_TimeOver, Answer_true, TimeOver_Stop;

  responder_arbiter #(
    .N_PLAYERS   (NP),
    .TICK_DIV    (10),
    .ANSWER_SECS (3),
    .BEEP_CYCLES (4)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .Key_In          (Key_In),
    .Host_Start      (Host_Start),
    .Host_Judge_True (Host_Judge_True),
    .Host_Clear      (Host_Clear),
    .Winner_Id       (Winner_Id),
    .Winner_Valid    (Winner_Valid),
    .Foul_Mask       (Foul_Mask),
    .Count_Sec       (Count_Sec),
    .Buzzer_Answer   (Buzzer_Answer),
    .Buzzer_TimeOver (Buzzer_TimeOver),
    .Answer_true     (Answer_true),
    .TimeOver_Stop   (TimeOver_Stop)
  );

  always #5 CLK = ~CLK;

  // Packed view: valid, id, foul, sec, buz_ans, buz_tov, ans_true, tov_stop
  logic [16:0] w_snap;
  assign w_snap = {Winner_Valid, Winner_Id, Foul_Mask, Count_Sec,
                   Buzzer_Answer, Buzzer_TimeOver, Answer_true, TimeOver_Stop};

  typedef struct {
    logic          rst;
    logic [NP-1:0] key;
    logic          start;
    logic          judge;
    logic          clr;
    logic [16:0]   exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] pk(input logic v, input logic [2:0] id,
                                     input logic [3:0] foul, input logic [4:0] sec,
                                     input logic ba, input logic bt,
                                     input logic at, input logic to);
    return {v, id, foul, sec, ba, bt, at, to};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] key, input logic start,
                              input logic judge, input logic clr, input logic [16:0] exp);
    vec_t v;
    v.rst = rst; v.key = key; v.start = start; v.judge = judge; v.clr = clr; v.exp = exp;
    return v;
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Open a round and press key k; returns just after the winning edge.
  task automatic win(input logic [3:0] k);
    Host_Start = 1'b1;
    step();
    Host_Start = 1'b0;
    Key_In = k;
    steps(3);
  endtask

  task automatic do_clear();
    Host_Clear = 1'b1;
    Key_In = '0;
    step();
    Host_Clear = 1'b0;
  endtask

  vec_t tbl[17];

  initial begin
    RST = 1'b1; Key_In = '0;
    Host_Start = 1'b0; Host_Judge_True = 1'b0; Host_Clear = 1'b0;

    // Basic round: start, key 2 wins three edges after rising, 4-cycle
    // answer beep, first second elapses 10 cycles after the win.
    tbl[0]  = mk(1, 4'b0000, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[1]  = mk(0, 4'b0000, 1, 0, 0, pk(0, 0, 0, 3, 0, 0, 0, 0));
    tbl[2]  = mk(0, 4'b0100, 1, 0, 0, pk(0, 0, 0, 3, 0, 0, 0, 0)); // start in ARMED ignored
    tbl[3]  = mk(0, 4'b0100, 0, 0, 0, pk(0, 0, 0, 3, 0, 0, 0, 0));
    tbl[4]  = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 1, 0, 0, 0)); // win edge
    tbl[5]  = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 1, 0, 0, 0));
    tbl[6]  = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 1, 0, 0, 0));
    tbl[7]  = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 1, 0, 0, 0));
    tbl[8]  = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 0, 0, 0, 0)); // beep ended
    tbl[9]  = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 0, 0, 0, 0));
    tbl[10] = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 0, 0, 0, 0));
    tbl[11] = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 0, 0, 0, 0));
    tbl[12] = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 0, 0, 0, 0));
    tbl[13] = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 3, 0, 0, 0, 0));
    tbl[14] = mk(0, 4'b0100, 0, 0, 0, pk(1, 2, 0, 2, 0, 0, 0, 0)); // 10 cycles after win
    tbl[15] = mk(0, 4'b0100, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0)); // clear
    tbl[16] = mk(0, 4'b0000, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)); // judge in IDLE ignored

    for (int i = 0; i < 17; i++) begin
      RST             = tbl[i].rst;
      Key_In          = tbl[i].key;
      Host_Start      = tbl[i].start;
      Host_Judge_True = tbl[i].judge;
      Host_Clear      = tbl[i].clr;
      step();
      Host_Start = 1'b0; Host_Judge_True = 1'b0; Host_Clear = 1'b0;
      check($sformatf("vec%0d", i), 32'(w_snap), 32'(tbl[i].exp));
    end
    steps(3);

    // Simultaneous keys 1 and 3: lowest index wins; later key 0 is ignored.
    win(4'b1010);
    check("simul_valid", 32'(Winner_Valid), 32'd1);
    check("simul_id", 32'(Winner_Id), 32'd1);
    Key_In = 4'b1011;
    steps(4);
    check("late_key_id", 32'(Winner_Id), 32'd1);
    do_clear();
    check("clear_all", 32'(w_snap), 32'd0);
    steps(3);

    // Foul in IDLE locks key 0 out of the round.
    Key_In = 4'b0001;
    steps(3);
    check("foul_mask", 32'(Foul_Mask), 32'b0001);
    check("foul_no_win", 32'(Winner_Valid), 32'd0);
    Key_In = 4'b0000;
    steps(3);
    win(4'b0001);
    check("fouled_ignored", 32'(Winner_Valid), 32'd0);
    Key_In = 4'b1001;
    steps(3);
    check("after_foul_valid", 32'(Winner_Valid), 32'd1);
    check("after_foul_id", 32'(Winner_Id), 32'd3);
    check("foul_kept", 32'(Foul_Mask), 32'b0001);
    do_clear();
    steps(3);

    // No judge: countdown reaches 0 at 30 cycles, time-over beep 4 cycles.
    win(4'b0100);
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k == 29) begin
        check("to_sec_before", 32'(Count_Sec), 32'd1);
        check("to_stop_before", 32'(TimeOver_Stop), 32'd0);
      end
      if (k == 30) begin
        check("to_sec_zero", 32'(Count_Sec), 32'd0);
        check("to_stop", 32'(TimeOver_Stop), 32'd1);
        check("to_beep_on", 32'(Buzzer_TimeOver), 32'd1);
      end
      if (k == 33) check("to_beep_last", 32'(Buzzer_TimeOver), 32'd1);
      if (k == 34) check("to_beep_off", 32'(Buzzer_TimeOver), 32'd0);
    end
    Host_Judge_True = 1'b1;
    step();
    Host_Judge_True = 1'b0;
    check("to_judge_ignored", 32'(Answer_true), 32'd0);
    check("to_hold_stop", 32'(TimeOver_Stop), 32'd1);
    check("to_no_underflow", 32'(Count_Sec), 32'd0);
    do_clear();
    steps(3);

    // Judge at cycle 15 freezes the countdown at 2.
    win(4'b0100);
    steps(14);
    Host_Judge_True = 1'b1;
    step();
    Host_Judge_True = 1'b0;
    check("judge_true", 32'(Answer_true), 32'd1);
    check("judge_sec", 32'(Count_Sec), 32'd2);
    steps(20);
    check("judge_frozen", 32'(Count_Sec), 32'd2);
    check("judge_no_to", 32'(TimeOver_Stop), 32'd0);
    do_clear();
    check("judge_clear", 32'(w_snap), 32'd0);
    steps(3);

    // Judge coinciding with the final tick: time-over wins.
    win(4'b0100);
    steps(29);
    Host_Judge_True = 1'b1;
    step();
    Host_Judge_True = 1'b0;
    check("tie_stop", 32'(TimeOver_Stop), 32'd1);
    check("tie_ans", 32'(Answer_true), 32'd0);
    check("tie_sec", 32'(Count_Sec), 32'd0);
    do_clear();
    steps(3);

    // Reset mid-answer while the answer beep is sounding.
    win(4'b0100);
    step();
    check("rst_pre_beep", 32'(Buzzer_Answer), 32'd1);
    RST = 1'b1;
    Key_In = '0;
    step();
    RST = 1'b0;
    check("rst_all_zero", 32'(w_snap), 32'd0);
    win(4'b0010);
    check("rst_after_valid", 32'(Winner_Valid), 32'd1);
    check("rst_after_id", 32'(Winner_Id), 32'd1);
    check("rst_after_beep", 32'(Buzzer_Answer), 32'd1);
    check("rst_after_sec", 32'(Count_Sec), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
